div: RTL

- Iterative restoring divider. It is the inverse companion of the team's shift-add `mult` block and uses the same start/busy handshake.
- Divides an unsigned N-bit dividend by an unsigned M-bit divisor and produces the quotient and remainder, one quotient bit per clock.
- Sits beside `mult` in the functional-circuitry datapath, so results from `mult` can be divided back.

---
 rtl/div_pkg.sv | 12 +
 rtl/div_step.sv | 22 ++
 rtl/div.sv | 83 ++++++++
 3 files changed

// File: rtl/div_pkg.sv
// div_pkg: shared state encoding, default widths and helpers for the divider
package div_pkg;
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WORK = 1'b1
  } state_t;
  localparam int DEF_N = 16;
  localparam int DEF_M = 8;
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/div_step.sv
// div_step: one restoring-division iteration, shift in a dividend bit and trial-subtract
module div_step #(
  parameter int M = 8
) (
  input  logic [M:0]   r,
  input  logic         d,
  input  logic [M-1:0] b,
  output logic [M:0]   r_nxt,
  output logic         q
);
  logic [M+1:0] t;
  logic [M+1:0] bx;
  logic [M+1:0] diff;
  // compare the shifted remainder with the divisor and restore when it does not fit
  always_comb begin
    t     = {r, d};
    bx    = (M+2)'(b);
    diff  = t - bx;
    q     = t >= bx;
    r_nxt = q ? diff[M:0] : t[M:0];
  end
endmodule

// File: rtl/div.sv
// div: iterative restoring divider, one quotient bit per clock with start/busy handshake
module div
  import div_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int M = DEF_M
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] a_bi,
  input  logic [M-1:0] b_bi,
  input  logic         start,
  output logic         busy_o,
  output logic [N-1:0] q_bo,
  output logic [M-1:0] r_bo,
  output logic         dz_o
);
  localparam int CW = cnt_w(N);
  state_t         state, state_nxt;
  logic [N-1:0]   d;
  logic [M-1:0]   b;
  logic [M:0]     r;
  logic [N-1:0]   q;
  logic [CW-1:0]  cnt;
  logic [M:0]     r_nxt;
  logic           q_bit;
  logic           launch;
  logic           last;
  logic           dz;
  div_step #(.M(M)) u_step (
    .r     (r),
    .d     (d[N-1]),
    .b     (b),
    .r_nxt (r_nxt),
    .q     (q_bit)
  );
  assign launch = (state == ST_IDLE) && start;
  assign last   = (state == ST_WORK) && (cnt == CW'(1));
  assign dz     = b == '0;
  assign busy_o = state == ST_WORK;
  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end
  // leave IDLE on a sampled start, return after the final iteration
  always_comb begin
    state_nxt = launch ? ST_WORK : last ? ST_IDLE : state;
  end
  // operand capture and per-cycle iteration; a zero divisor finishes after one cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d   <= '0;
      b   <= '0;
      r   <= '0;
      q   <= '0;
      cnt <= '0;
    end else if (launch) begin
      d   <= a_bi;
      b   <= b_bi;
      r   <= '0;
      q   <= '0;
      cnt <= (b_bi == '0) ? CW'(1) : CW'(N);
    end else if (state == ST_WORK) begin
      d   <= {d[N-2:0], 1'b0};
      r   <= r_nxt;
      q   <= {q[N-2:0], q_bit};
      cnt <= cnt - CW'(1);
    end
  end
  // results update only at completion and hold until the next one
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_bo <= '0;
      r_bo <= '0;
      dz_o <= 1'b0;
    end else if (last) begin
      q_bo <= dz ? '1 : {q[N-2:0], q_bit};
      r_bo <= dz ? '0 : r_nxt[M-1:0];
      dz_o <= dz;
    end
  end
endmodule
